// File: rtl/fsm_button_array.sv
// Multi-channel push-button front end: per channel a two-flop synchroniser, a
// debouncer and a press/long-press FSM driving a toggle or momentary state level.
module fsm_button_array #(
  parameter int CH       = 4,
  parameter int DB_CNT   = 4,
  parameter int LONG_CNT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] button,
  input  logic [CH-1:0] mode,
  input  logic          clear,
  output logic [CH-1:0] state,
  output logic [CH-1:0] press,
  output logic [CH-1:0] long_press
);

  localparam int DBW = $clog2(DB_CNT + 1);
  localparam int HW  = $clog2(LONG_CNT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } fsm_t;

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic           sync1, sync2;
      logic           db_reg, db_next;
      logic [DBW-1:0] cnt_reg, cnt_next;
      logic [HW-1:0]  hold_reg, hold_next;
      fsm_t           fsm_reg, fsm_next;
      logic           state_reg, state_next;
      logic           press_reg, press_next;
      logic           long_reg, long_next;
      logic           rise, fall;

      // The edge that accepts a new level also drives the FSM, so pulses and
      // state line up with the debounced level rather than trailing it by one.
      always_comb begin
        db_next  = db_reg;
        cnt_next = '0;
        rise     = 1'b0;
        fall     = 1'b0;
        if (sync2 != db_reg) begin
          if (cnt_reg == DBW'(DB_CNT - 1)) begin
            db_next = sync2;
            rise    = sync2;
            fall    = ~sync2;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      always_comb begin
        fsm_next   = fsm_reg;
        hold_next  = hold_reg;
        press_next = 1'b0;
        long_next  = 1'b0;
        case (fsm_reg)
          IDLE: begin
            if (rise) begin
              fsm_next   = PRESSED;
              hold_next  = '0;
              press_next = 1'b1;
            end
          end
          PRESSED: begin
            if (fall) begin
              fsm_next  = IDLE;
              hold_next = '0;
            end else if (hold_reg == HW'(LONG_CNT - 1)) begin
              fsm_next  = HELD;
              hold_next = '0;
              long_next = 1'b1;
            end else begin
              hold_next = hold_reg + 1'b1;
            end
          end
          HELD: begin
            if (fall) begin
              fsm_next = IDLE;
            end
          end
          default: begin
            fsm_next  = IDLE;
            hold_next = '0;
          end
        endcase
      end

      // Momentary channels track the debounced level; clear only touches toggle channels.
      always_comb begin
        state_next = state_reg;
        if (mode[gi]) begin
          state_next = db_next;
        end else if (clear) begin
          state_next = 1'b0;
        end else if (press_next) begin
          state_next = ~state_reg;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1     <= 1'b0;
          sync2     <= 1'b0;
          db_reg    <= 1'b0;
          cnt_reg   <= '0;
          hold_reg  <= '0;
          fsm_reg   <= IDLE;
          state_reg <= 1'b0;
          press_reg <= 1'b0;
          long_reg  <= 1'b0;
        end else begin
          sync1     <= button[gi];
          sync2     <= sync1;
          db_reg    <= db_next;
          cnt_reg   <= cnt_next;
          hold_reg  <= hold_next;
          fsm_reg   <= fsm_next;
          state_reg <= state_next;
          press_reg <= press_next;
          long_reg  <= long_next;
        end
      end

      assign state[gi]      = state_reg;
      assign press[gi]      = press_reg;
      assign long_press[gi] = long_reg;
    end
  endgenerate

endmodule
